// File: rtl/quad_inv_checker.sv
// Self-test sequencer for a quad inverter: drives LFSR stimulus and checks for inverted responses.
// Optional first-failure capture ports are built when QIC_FAIL_CAPTURE_EN is defined.
module quad_inv_checker #(
  parameter int unsigned NUM_VEC = 100,
  parameter int unsigned SETTLE  = 2,
  parameter logic [7:0]  SEED    = 8'hA5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       a,
  output logic       b,
  output logic       c,
  output logic       d,
  input  logic       ab,
  input  logic       bb,
  input  logic       cb,
  input  logic       db,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] vec_count,
`ifdef QIC_FAIL_CAPTURE_EN
  output logic [3:0] fail_vec,
  output logic [3:0] fail_resp,
`endif
  output logic [7:0] err_count
);

  // state | meaning
  // IDLE  | waiting for start, stimulus 0
  // APPLY | launch next LFSR nibble onto a..d
  // WAIT  | settle countdown
  // CHECK | compare response, count vector
  // DONE  | results held, stimulus 0
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_APPLY = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [7:0] NUM_VEC_L = 8'(NUM_VEC);
  localparam logic [3:0] SETTLE_L  = 4'(SETTLE);

  logic [2:0] state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [3:0] stim_q, stim_d;
  logic [3:0] settle_q, settle_d;
  logic [7:0] vec_q, vec_d;
  logic [7:0] err_q, err_d;

  logic [3:0] resp;
  logic       mismatch;
  logic [7:0] vec_inc;
  logic       lfsr_fb;

  assign resp     = {ab, bb, cb, db};
  assign mismatch = (resp != ~stim_q);
  assign vec_inc  = vec_q + 8'd1;
  assign lfsr_fb  = lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3];

`ifdef QIC_FAIL_CAPTURE_EN
  logic [3:0] fail_vec_q, fail_vec_d;
  logic [3:0] fail_resp_q, fail_resp_d;
`endif

  always_comb begin
    state_d  = state_q;
    lfsr_d   = lfsr_q;
    stim_d   = stim_q;
    settle_d = settle_q;
    vec_d    = vec_q;
    err_d    = err_q;
`ifdef QIC_FAIL_CAPTURE_EN
    fail_vec_d  = fail_vec_q;
    fail_resp_d = fail_resp_q;
`endif
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          lfsr_d  = SEED;
          vec_d   = 8'd0;
          err_d   = 8'd0;
          state_d = S_APPLY;
`ifdef QIC_FAIL_CAPTURE_EN
          fail_vec_d  = 4'd0;
          fail_resp_d = 4'd0;
`endif
        end
      end
      S_APPLY: begin
        stim_d   = lfsr_q[3:0];
        settle_d = SETTLE_L;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        settle_d = settle_q - 4'd1;
        if (settle_q == 4'd1) state_d = S_CHECK;
      end
      S_CHECK: begin
        vec_d  = vec_inc;
        lfsr_d = {lfsr_q[6:0], lfsr_fb};
        if (mismatch) begin
          err_d = err_q + 8'd1;
`ifdef QIC_FAIL_CAPTURE_EN
          // err_q still zero means this is the first bad vector of the run
          if (err_q == 8'd0) begin
            fail_vec_d  = stim_q;
            fail_resp_d = resp;
          end
`endif
        end
        if (vec_inc == NUM_VEC_L) begin
          state_d = S_DONE;
          stim_d  = 4'd0;
        end else begin
          state_d = S_APPLY;
        end
      end
      default: begin
        state_d = S_IDLE;
        stim_d  = 4'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      lfsr_q   <= SEED;
      stim_q   <= 4'd0;
      settle_q <= 4'd0;
      vec_q    <= 8'd0;
      err_q    <= 8'd0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      stim_q   <= stim_d;
      settle_q <= settle_d;
      vec_q    <= vec_d;
      err_q    <= err_d;
    end
  end

`ifdef QIC_FAIL_CAPTURE_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fail_vec_q  <= 4'd0;
      fail_resp_q <= 4'd0;
    end else begin
      fail_vec_q  <= fail_vec_d;
      fail_resp_q <= fail_resp_d;
    end
  end

  assign fail_vec  = fail_vec_q;
  assign fail_resp = fail_resp_q;
`endif

  assign {a, b, c, d} = stim_q;
  assign busy      = (state_q == S_APPLY) || (state_q == S_WAIT) || (state_q == S_CHECK);
  assign done      = (state_q == S_DONE);
  assign pass      = (state_q == S_DONE) && (err_q == 8'd0);
  assign vec_count = vec_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_quad_inv_checker.sv
// Directed bench for quad_inv_checker: default instance plus a NUM_VEC=1/SETTLE=1 instance.
module tb_quad_inv_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, start_s;
  int         mode;
  logic       a, b, c, d, ab, bb, cb, db;
  logic       busy, done, pass;
  logic [7:0] vec_count, err_count;
  logic       a_s, b_s, c_s, d_s;
  logic       busy_s, done_s, pass_s;
  logic [7:0] vec_s, err_s;
`ifdef QIC_FAIL_CAPTURE_EN
  logic [3:0] fail_vec, fail_resp, fail_vec_s, fail_resp_s;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // mode 0: true inverters, 1: buffers, 2: db stuck at 0
  assign ab = (mode == 1) ? a : ~a;
  assign bb = (mode == 1) ? b : ~b;
  assign cb = (mode == 1) ? c : ~c;
  assign db = (mode == 2) ? 1'b0 : ((mode == 1) ? d : ~d);

  quad_inv_checker u_dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .a(a), .b(b), .c(c), .d(d),
    .ab(ab), .bb(bb), .cb(cb), .db(db),
    .busy(busy), .done(done), .pass(pass), .vec_count(vec_count),
`ifdef QIC_FAIL_CAPTURE_EN
    .fail_vec(fail_vec), .fail_resp(fail_resp),
`endif
    .err_count(err_count)
  );

  quad_inv_checker #(.NUM_VEC(1), .SETTLE(1)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s),
    .a(a_s), .b(b_s), .c(c_s), .d(d_s),
    .ab(~a_s), .bb(~b_s), .cb(~c_s), .db(~d_s),
    .busy(busy_s), .done(done_s), .pass(pass_s), .vec_count(vec_s),
`ifdef QIC_FAIL_CAPTURE_EN
    .fail_vec(fail_vec_s), .fail_resp(fail_resp_s),
`endif
    .err_count(err_s)
  );

  typedef struct {
    int         mode;
    logic [7:0] exp_err;
    logic       exp_pass;
    logic [3:0] exp_fv;
    logic [3:0] exp_fr;
  } run_vec_t;

  run_vec_t tbl[3];

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Called just after a negedge; start is sampled at the next posedge.
  // lat = posedges from the start-sampling edge until done is seen high.
  task automatic run(input bit hold, output int lat);
    logic [7:0] m;
    m     = 8'hA5;
    lat   = -1;
    start = 1'b1;
    for (int k = 1; k <= 600; k++) begin
      @(negedge clk);
      if (!hold && k == 1) start = 1'b0;
      if (k == 1) begin
        chk("start_busy", busy, 1);
        chk("start_vec_clr", vec_count, 0);
        chk("start_err_clr", err_count, 0);
      end
      if (k <= 14 && k >= 2 && ((k - 2) % 4) == 0) begin
        chk("stimulus", {a, b, c, d}, m[3:0]);
        m = lfsr_next(m);
      end
      if (done) begin
        lat = k - 1;
        break;
      end
    end
  endtask

  initial begin
    int         lat;
    logic [7:0] l;
    logic [7:0] stuck_cnt;
    logic [3:0] stuck_fv, stuck_fr;

    l = 8'hA5;
    stuck_cnt = 8'd0;
    stuck_fv = 4'd0;
    stuck_fr = 4'd0;
    for (int i = 0; i < 100; i++) begin
      if (!l[0]) begin
        if (stuck_cnt == 8'd0) begin
          stuck_fv = l[3:0];
          stuck_fr = {~l[3:1], 1'b0};
        end
        stuck_cnt++;
      end
      l = lfsr_next(l);
    end
    tbl[0] = '{0, 8'd0,   1'b1, 4'h0,     4'h0};
    tbl[1] = '{1, 8'd100, 1'b0, 4'h5,     4'h5};
    tbl[2] = '{2, stuck_cnt, 1'b0, stuck_fv, stuck_fr};

    rst_n = 1'b0; start = 1'b0; start_s = 1'b0; mode = 0;
    #2;
    chk("rst_stim", {a, b, c, d}, 0);
    chk("rst_flags", {busy, done, pass}, 0);
    chk("rst_vec", vec_count, 0);
    chk("rst_err", err_count, 0);
    chk("rst_small", {busy_s, done_s, pass_s, vec_s}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 3; t++) begin
      mode = tbl[t].mode;
      run(1'b0, lat);
      chk("latency", lat, 400);
      chk("vec_count", vec_count, 100);
      chk("err_count", err_count, tbl[t].exp_err);
      chk("pass", pass, tbl[t].exp_pass);
      chk("done_stim", {a, b, c, d}, 0);
`ifdef QIC_FAIL_CAPTURE_EN
      chk("fail_vec", fail_vec, tbl[t].exp_fv);
      chk("fail_resp", fail_resp, tbl[t].exp_fr);
`endif
      repeat (3) @(negedge clk);
      chk("done_hold", {done, busy, pass}, {1'b1, 1'b0, tbl[t].exp_pass});
      chk("err_hold", err_count, tbl[t].exp_err);
    end

    // Reset during vector 50
    mode = 0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (198) @(negedge clk);
    chk("mid_vec", vec_count, 49);
    chk("mid_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_stim", {a, b, c, d}, 0);
    chk("arst_flags", {busy, done, pass}, 0);
    chk("arst_cnt", {vec_count, err_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run(1'b0, lat);
    chk("rerun_latency", lat, 400);
    chk("rerun_pass", {pass, vec_count}, {1'b1, 8'd100});

    // start held high: no restart while busy, immediate rerun from DONE
    run(1'b1, lat);
    chk("held_latency", lat, 400);
    chk("held_vec", vec_count, 100);
    run(1'b0, lat);
    chk("held_rerun_latency", lat, 400);
    chk("held_rerun_pass", {pass, vec_count, err_count}, {1'b1, 8'd100, 8'd0});

    // NUM_VEC=1, SETTLE=1 instance
    lat = -1;
    start_s = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) start_s = 1'b0;
      if (k == 2) chk("small_stim", {a_s, b_s, c_s, d_s}, 4'h5);
      if (done_s) begin
        lat = k - 1;
        break;
      end
    end
    chk("small_latency", lat, 3);
    chk("small_vec", vec_s, 1);
    chk("small_pass", {pass_s, err_s}, {1'b1, 8'd0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/quad_inv_checker.md
QUAD_INV_CHECKER -- requirements
Module: quad_inv_checker

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter NUM_VEC SHALL default to 100 and set the vectors per run (legal range 1..255).
REQ-003 Parameter SETTLE SHALL default to 2 and set the wait cycles between stimulus launch and response sample (legal range 1..15).
REQ-004 Parameter SEED SHALL default to 8'hA5 and set the LFSR load value (nonzero).
REQ-005 Port clk, input, 1 bit, SHALL be the rising-edge clock.
REQ-006 Port rst_n, input, 1 bit, SHALL be the asynchronous active-low reset.
REQ-007 Port start, input, 1 bit, SHALL request a run when high in IDLE or DONE.
REQ-008 Ports a, b, c, d, output, 1 bit each, SHALL be the registered stimulus to the device under test.
REQ-009 Ports ab, bb, cb, db, input, 1 bit each, SHALL be the device responses, expected to be ~a, ~b, ~c, ~d.
REQ-010 Port busy, output, 1 bit, SHALL be high in APPLY, WAIT and CHECK.
REQ-011 Port done, output, 1 bit, SHALL be high in DONE only.
REQ-012 Port pass, output, 1 bit, SHALL equal (err_count==0) while done is high, and 0 otherwise.
REQ-013 Ports vec_count and err_count, output, 8 bits each, SHALL give the vectors checked and mismatching vectors in the current or last run.

Function
REQ-014 FSM states SHALL be IDLE, APPLY, WAIT, CHECK and DONE.
REQ-015 IDLE or DONE with start=1 SHALL load the LFSR with SEED, clear both counters, and go to APPLY.
REQ-016 The LFSR SHALL be an 8-bit Fibonacci LFSR that shifts left with input bit lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3], and SHALL advance only on CHECK exit.
REQ-017 APPLY SHALL register {a,b,c,d} = lfsr[3:0], load the settle counter with SETTLE, and go to WAIT.
REQ-018 WAIT SHALL decrement the settle counter each cycle and go to CHECK after exactly SETTLE cycles.
REQ-019 CHECK SHALL compare {ab,bb,cb,db} with ~{a,b,c,d}, increment err_count on any bit mismatch, and increment vec_count.
REQ-020 CHECK SHALL go to DONE when the incremented vec_count equals NUM_VEC, and to APPLY otherwise.
REQ-021 Each vector SHALL occupy exactly SETTLE+2 cycles.
REQ-022 done SHALL rise NUM_VEC*(SETTLE+2) cycles after the edge that samples start.
REQ-023 Stimulus SHALL be held stable through WAIT and CHECK, and SHALL be 4'b0000 in IDLE and DONE.
REQ-024 start SHALL be ignored while busy is high.
REQ-025 DONE SHALL hold counters and pass until a new start is sampled.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, a=b=c=d=0, busy=done=pass=0, vec_count=err_count=0, settle counter 0, LFSR=SEED.
REQ-027 Reset mid-run SHALL abandon the run; the next run SHALL restart from the first vector, {a,b,c,d}=4'h5 with default SEED.

Configuration
REQ-028 With macro QIC_FAIL_CAPTURE_EN defined, outputs fail_vec[3:0] and fail_resp[3:0] SHALL exist and hold the stimulus and response of the first mismatching vector in the run.
REQ-029 With QIC_FAIL_CAPTURE_EN defined, fail_vec and fail_resp SHALL clear on reset and on run start.
REQ-030 Without QIC_FAIL_CAPTURE_EN, those ports and their registers SHALL be absent, with all other behaviour unchanged.

Verification
REQ-031 Responses wired as true inverters, defaults, 1-cycle start pulse -> done high 400 cycles later; pass=1, vec_count=100, err_count=0.
REQ-032 Responses wired as buffers (ab=a etc.) -> done with err_count=100, pass=0; with macro, fail_vec=4'h5 and fail_resp=4'h5.
REQ-033 db stuck at 0, other responses inverting -> err_count equals the number of vectors with lfsr[0]=0 per the reference LFSR model; pass=0.
REQ-034 rst_n pulsed low during vector 50 -> all outputs 0 asynchronously; the next start reproduces the sequence from {a,b,c,d}=4'h5.
REQ-035 start held high through a run -> no restart while busy; in DONE, start starts an identical rerun with counters cleared.
REQ-036 NUM_VEC=1, SETTLE=1 -> done 3 cycles after start is sampled; vec_count=1.
